// File: rtl/clock_divider_multi_if.sv
// Configuration and waveform signals of the multi-channel clock divider.
// Slice i of ratio/high_cnt is bits [i*CNT_W +: CNT_W] and belongs to channel i.
interface clock_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] ratio;
  logic [NUM_CH*CNT_W-1:0] high_cnt;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output en, load, ratio, high_cnt,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, load, ratio, high_cnt,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with per-channel duty, enable and
// boundary-synchronised reconfiguration.
//
// state | meaning
// IDLE  | channel stopped, outputs low, loads write the active config directly
// RUN   | counting 0..act_ratio-1, loads are held pending until the next wrap
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  clock_divider_multi_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q     [NUM_CH];
  logic [CNT_W-1:0]   cnt_q       [NUM_CH];
  logic [CNT_W-1:0]   act_ratio_q [NUM_CH];
  logic [CNT_W-1:0]   act_high_q  [NUM_CH];
  logic [CNT_W-1:0]   pnd_ratio_q [NUM_CH];
  logic [CNT_W-1:0]   pnd_high_q  [NUM_CH];
  logic [NUM_CH-1:0]  pend_q;
  logic [NUM_CH-1:0]  clk_q;
  logic [NUM_CH-1:0]  tick_q;

  logic [CNT_W-1:0]   ld_ratio    [NUM_CH];
  logic [CNT_W-1:0]   ld_high     [NUM_CH];
  logic [CNT_W-1:0]   cnt_inc     [NUM_CH];
  logic [NUM_CH-1:0]  last;

  // Ratios below 2 are clamped so act_ratio-1 is always at least 1.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ld_ratio[i] = bus.ratio[i*CNT_W +: CNT_W];
      if (ld_ratio[i] < CNT_W'(2))
        ld_ratio[i] = CNT_W'(2);
      ld_high[i] = bus.high_cnt[i*CNT_W +: CNT_W];
      cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      last[i]    = (cnt_q[i] == (act_ratio_q[i] - CNT_W'(1)));
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        state_q[i]     <= IDLE;
        cnt_q[i]       <= '0;
        act_ratio_q[i] <= CNT_W'(2);
        act_high_q[i]  <= CNT_W'(1);
        pnd_ratio_q[i] <= CNT_W'(2);
        pnd_high_q[i]  <= CNT_W'(1);
        pend_q[i]      <= 1'b0;
        clk_q[i]       <= 1'b0;
        tick_q[i]      <= 1'b0;
      end else begin
        case (state_q[i])
          IDLE: begin
            cnt_q[i]  <= '0;
            clk_q[i]  <= 1'b0;
            tick_q[i] <= 1'b0;
            if (bus.load[i]) begin
              act_ratio_q[i] <= ld_ratio[i];
              act_high_q[i]  <= ld_high[i];
            end
            if (bus.en[i]) begin
              state_q[i] <= RUN;
              tick_q[i]  <= 1'b1;
              clk_q[i]   <= bus.load[i] ? (ld_high[i] != '0) : (act_high_q[i] != '0);
            end
          end
          RUN: begin
            if (!bus.en[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
              clk_q[i]   <= 1'b0;
              tick_q[i]  <= 1'b0;
              pend_q[i]  <= 1'b0;
              if (pend_q[i]) begin
                act_ratio_q[i] <= pnd_ratio_q[i];
                act_high_q[i]  <= pnd_high_q[i];
              end
              // A load while stopping is the newest config, so it overrides the commit.
              if (bus.load[i]) begin
                act_ratio_q[i] <= ld_ratio[i];
                act_high_q[i]  <= ld_high[i];
              end
            end else begin
              if (last[i]) begin
                cnt_q[i]  <= '0;
                tick_q[i] <= 1'b1;
                if (pend_q[i]) begin
                  act_ratio_q[i] <= pnd_ratio_q[i];
                  act_high_q[i]  <= pnd_high_q[i];
                  pend_q[i]      <= 1'b0;
                  clk_q[i]       <= (pnd_high_q[i] != '0);
                end else begin
                  clk_q[i]       <= (act_high_q[i] != '0);
                end
              end else begin
                cnt_q[i]  <= cnt_inc[i];
                tick_q[i] <= 1'b0;
                clk_q[i]  <= (cnt_inc[i] < act_high_q[i]);
              end
              // Placed after the wrap so a same-edge load re-arms pending for the next boundary.
              if (bus.load[i]) begin
                pnd_ratio_q[i] <= ld_ratio[i];
                pnd_high_q[i]  <= ld_high[i];
                pend_q[i]      <= 1'b1;
              end
            end
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: vector table, directed corner
// sequences and randomized traffic against a period-position reference model.
module tb_clock_divider_multi;
  localparam int NC = 4;
  localparam int CW = 16;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  clock_divider_multi_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  clock_divider_multi #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_pass  = 0;

  logic [NC-1:0]    cur_en    = '0;
  logic [NC*CW-1:0] cur_ratio = '0;
  logic [NC*CW-1:0] cur_high  = '0;

  // Reference model: a running channel sits at position pos within a period of
  // m_per cycles; waveform follows directly from pos and the duty length.
  bit m_run  [NC];
  int m_pos  [NC];
  int m_per  [NC];
  int m_hi   [NC];
  int m_nper [NC];
  int m_nhi  [NC];
  bit m_pend [NC];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic rst, input logic [NC-1:0] ld);
    for (int i = 0; i < NC; i++) begin
      int r, h;
      r = int'(cur_ratio[i*CW +: CW]);
      if (r < 2) r = 2;
      h = int'(cur_high[i*CW +: CW]);
      if (rst) begin
        m_run[i] = 0; m_pos[i] = 0; m_per[i] = 2; m_hi[i] = 1;
        m_nper[i] = 2; m_nhi[i] = 1; m_pend[i] = 0;
      end else if (!m_run[i]) begin
        if (ld[i]) begin m_per[i] = r; m_hi[i] = h; end
        if (cur_en[i]) begin m_run[i] = 1; m_pos[i] = 0; end
      end else if (cur_en[i]) begin
        m_pos[i] = (m_pos[i] + 1) % m_per[i];
        if (m_pos[i] == 0 && m_pend[i]) begin
          m_per[i] = m_nper[i]; m_hi[i] = m_nhi[i]; m_pend[i] = 0;
        end
        if (ld[i]) begin m_nper[i] = r; m_nhi[i] = h; m_pend[i] = 1; end
      end else begin
        m_run[i] = 0; m_pos[i] = 0;
        if (m_pend[i]) begin m_per[i] = m_nper[i]; m_hi[i] = m_nhi[i]; m_pend[i] = 0; end
        if (ld[i]) begin m_per[i] = r; m_hi[i] = h; end
      end
    end
  endtask

  task automatic model_compare();
    logic [NC-1:0] e_clk, e_tick, e_pend;
    for (int i = 0; i < NC; i++) begin
      e_clk[i]  = m_run[i] && (m_pos[i] < m_hi[i]);
      e_tick[i] = m_run[i] && (m_pos[i] == 0);
      e_pend[i] = m_pend[i];
    end
    chk("model_clk_out", int'(bus.clk_out), int'(e_clk));
    chk("model_tick",    int'(bus.tick),    int'(e_tick));
    chk("model_pending", int'(bus.pending), int'(e_pend));
  endtask

  task automatic step(input logic rst, input logic [NC-1:0] ld);
    reset        = rst;
    bus.load     = ld;
    bus.en       = cur_en;
    bus.ratio    = cur_ratio;
    bus.high_cnt = cur_high;
    @(posedge clk_in);
    #1;
    model_edge(rst, ld);
    model_compare();
  endtask

  task automatic set_cfg(input int ch, input int r, input int h);
    cur_ratio[ch*CW +: CW] = CW'(r);
    cur_high[ch*CW +: CW]  = CW'(h);
  endtask

  typedef struct {
    logic en0;
    logic load0;
    int   r0;
    int   h0;
    logic e_clk;
    logic e_tick;
    logic e_pend;
  } vec_t;

  vec_t vtab [19];

  initial begin
    int cnt_a, cnt_b, cnt_c;
    bit found;

    vtab[0]  = '{0, 1, 4, 2, 0, 0, 0};
    vtab[1]  = '{1, 0, 0, 0, 1, 1, 0};
    vtab[2]  = '{1, 0, 0, 0, 1, 0, 0};
    vtab[3]  = '{1, 0, 0, 0, 0, 0, 0};
    vtab[4]  = '{1, 0, 0, 0, 0, 0, 0};
    vtab[5]  = '{1, 0, 0, 0, 1, 1, 0};
    vtab[6]  = '{1, 1, 6, 3, 1, 0, 1};
    vtab[7]  = '{1, 0, 0, 0, 0, 0, 1};
    vtab[8]  = '{1, 0, 0, 0, 0, 0, 1};
    vtab[9]  = '{1, 0, 0, 0, 1, 1, 0};
    vtab[10] = '{1, 0, 0, 0, 1, 0, 0};
    vtab[11] = '{1, 0, 0, 0, 1, 0, 0};
    vtab[12] = '{1, 0, 0, 0, 0, 0, 0};
    vtab[13] = '{1, 0, 0, 0, 0, 0, 0};
    vtab[14] = '{1, 0, 0, 0, 0, 0, 0};
    vtab[15] = '{1, 0, 0, 0, 1, 1, 0};
    vtab[16] = '{1, 0, 0, 0, 1, 0, 0};
    vtab[17] = '{0, 0, 0, 0, 0, 0, 0};
    vtab[18] = '{1, 0, 0, 0, 1, 1, 0};

    // Reset state
    step(1'b1, '0);
    step(1'b1, 4'b1111);
    chk("reset_clk_out", int'(bus.clk_out), 0);
    chk("reset_pending", int'(bus.pending), 0);

    // Table: ch0 basic pattern, mid-period reload, stop in high phase, restart
    for (int v = 0; v < 19; v++) begin
      cur_en[0] = vtab[v].en0;
      set_cfg(0, vtab[v].r0, vtab[v].h0);
      step(1'b0, {3'b000, vtab[v].load0});
      chk($sformatf("vec%0d_clk0", v),  int'(bus.clk_out[0]), int'(vtab[v].e_clk));
      chk($sformatf("vec%0d_tick0", v), int'(bus.tick[0]),    int'(vtab[v].e_tick));
      chk($sformatf("vec%0d_pend0", v), int'(bus.pending[0]), int'(vtab[v].e_pend));
    end

    // ch1 5/2 and ch2 5/0 alongside running ch0
    set_cfg(1, 5, 2);
    set_cfg(2, 5, 0);
    step(1'b0, 4'b0110);
    cur_en[2:1] = 2'b11;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0);
      cnt_a += int'(bus.tick[2]);
      cnt_b += int'(bus.clk_out[2]);
      cnt_c += int'(bus.clk_out[1]);
    end
    chk("ch2_tick_count", cnt_a, 4);
    chk("ch2_high_count", cnt_b, 0);
    chk("ch1_high_count", cnt_c, 8);

    // Load on the exact wrap edge of ch0 (running 6/3)
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_pos[0] == 5) found = 1;
      else step(1'b0, '0);
    end
    chk("wrap_sync_found", int'(found), 1);
    set_cfg(0, 2, 1);
    step(1'b0, 4'b0001);
    chk("wrapload_tick0", int'(bus.tick[0]), 1);
    chk("wrapload_clk0",  int'(bus.clk_out[0]), 1);
    chk("wrapload_pend0", int'(bus.pending[0]), 1);
    for (int k = 0; k < 5; k++) step(1'b0, '0);
    chk("oldcfg_pend0", int'(bus.pending[0]), 1);
    step(1'b0, '0);
    chk("newcfg_tick0", int'(bus.tick[0]), 1);
    chk("newcfg_pend0", int'(bus.pending[0]), 0);
    step(1'b0, '0);
    chk("newcfg_low0", int'(bus.clk_out[0]), 0);

    // Two loads in one period on ch3; only the second must apply
    set_cfg(3, 8, 4);
    cur_en[3] = 1'b1;
    step(1'b0, 4'b1000);
    set_cfg(3, 3, 1);
    step(1'b0, 4'b1000);
    set_cfg(3, 5, 2);
    step(1'b0, 4'b1000);
    for (int k = 0; k < 6; k++) step(1'b0, '0);
    chk("twoload_tick3", int'(bus.tick[3]), 1);
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0);
      cnt_a += int'(bus.tick[3]);
    end
    chk("twoload_period5_ticks", cnt_a, 2);

    // Clamp: ratio 0 and 1 behave as 2
    cur_en[0] = 1'b0;
    step(1'b0, '0);
    set_cfg(0, 0, 1);
    cur_en[0] = 1'b1;
    step(1'b0, 4'b0001);
    chk("clamp0_a", int'({bus.clk_out[0], bus.tick[0]}), 3);
    step(1'b0, '0);
    chk("clamp0_b", int'({bus.clk_out[0], bus.tick[0]}), 0);
    step(1'b0, '0);
    chk("clamp0_c", int'({bus.clk_out[0], bus.tick[0]}), 3);
    cur_en[0] = 1'b0;
    set_cfg(0, 1, 1);
    step(1'b0, 4'b0001);
    cur_en[0] = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, '0);
    chk("clamp1_clk0", int'(bus.clk_out[0]), 0);

    // high_cnt >= ratio: constant high
    cur_en[0] = 1'b0;
    set_cfg(0, 3, 7);
    step(1'b0, 4'b0001);
    cur_en[0] = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, '0);
      cnt_a += int'(bus.clk_out[0]);
      cnt_b += int'(bus.tick[0]);
    end
    chk("dutyfull_high_count", cnt_a, 9);
    chk("dutyfull_tick_count", cnt_b, 3);

    // Reset mid-run with a pending config
    set_cfg(0, 5, 2);
    step(1'b0, 4'b0001);
    chk("prereset_pend0", int'(bus.pending[0]), 1);
    step(1'b1, '0);
    chk("midreset_clk_out", int'(bus.clk_out), 0);
    chk("midreset_tick",    int'(bus.tick), 0);
    chk("midreset_pending", int'(bus.pending), 0);
    cur_en = 4'b0001;
    step(1'b0, '0);
    chk("default_a", int'({bus.clk_out[0], bus.tick[0]}), 3);
    step(1'b0, '0);
    chk("default_b", int'({bus.clk_out[0], bus.tick[0]}), 0);
    step(1'b0, '0);
    chk("default_c", int'({bus.clk_out[0], bus.tick[0]}), 3);

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      logic [NC-1:0] ld;
      for (int i = 0; i < NC; i++) begin
        cur_en[i] = ($urandom_range(0, 11) != 0);
        ld[i]     = ($urandom_range(0, 9) == 0);
        set_cfg(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
      end
      step(($urandom_range(0, 99) == 0), ld);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the single-channel clock divider. Each channel produces an independent divided clock-enable waveform from one clk_in.
- Each channel has a programmable integer period, a programmable high-phase length (duty), and a per-channel enable.
- New period and duty values are taken in glitch-free, only at a period boundary.
- Each channel emits a one-cycle tick at the start of every period. The block sits in the clocking and timing section and feeds peripherals that need slow strobes or divided clocks.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 16, width of the per-channel counter and of each ratio and high_cnt field.

Ports:
- clk_in  input  1  single block clock.
- reset  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable; bit i controls channel i.
- load  input  NUM_CH  per-channel strobe; capture ratio/high_cnt slice i.
- ratio  input  NUM_CH*CNT_W  period in clk_in cycles; slice i = bits [i*CNT_W +: CNT_W].
- high_cnt  input  NUM_CH*CNT_W  high-phase length in cycles; same slicing as ratio.
- clk_out  output  NUM_CH  divided waveform, registered.
- tick  output  NUM_CH  one-cycle pulse in the first cycle of each period, registered.
- pending  output  NUM_CH  a loaded configuration is waiting for the next boundary.

Behaviour:
- Reset (sampled on a clk_in edge while reset=1):
  - All channels go to IDLE; cnt=0, clk_out=0, tick=0, pending=0.
  - Active config: act_ratio=2, act_high=1.
  - Reset overrides en and load on the same edge.
- Channels are fully independent. All rules below apply per channel i.
- Capture clamp: a loaded ratio value below 2 is stored as 2. high_cnt is stored unmodified.
- Waveform invariant in RUN: in the cycle where cnt==k, clk_out==(k < act_high) and tick==(k==0).
  - act_high=0 gives constant low.
  - act_high >= act_ratio gives constant high.
  - tick keeps pulsing every act_ratio cycles in both cases.
- State IDLE:
  - cnt=0, clk_out=0, tick=0.
  - load=1: the active config is written directly on that edge; pending stays 0.
  - Edge with en=1: go to RUN with cnt=0, clk_out=(act_high>0), tick=1.
  - If load and en are both asserted on that edge, the newly loaded values govern the first period; compare against the clamped value.
- State RUN, edge with en=1:
  - If cnt==act_ratio-1: wrap to cnt=0 and tick=1. If pending=1, copy the pending config to active and clear pending. clk_out=(0 < new act_high).
  - Otherwise: cnt=cnt+1, tick=0, clk_out=(cnt+1 < act_high).
- load in RUN:
  - Writes the pending registers and sets pending=1.
  - Several loads before one boundary: the last load wins.
  - A load on the same edge as a wrap does not affect that wrap. It takes effect at the following boundary, and pending reads 1 after that edge.
- RUN, edge with en=0:
  - Immediate stop: go to IDLE, cnt=0, clk_out=0, tick=0. A high phase may be truncated; this is accepted.
  - A pending config is committed to active on that edge and pending clears.
- Counter arithmetic:
  - Unsigned CNT_W bits. Comparisons use act_ratio-1, which is never below 1 thanks to the clamp.
  - The counter never exceeds act_ratio-1, so there is no overflow.
  - Maximum period is 2^CNT_W-1 cycles.
- Latency: en, load and reset take effect on the first clk_in edge that samples them. Outputs change on that same edge.

Test Plan:
- Reset, then ch0 load ratio=4 high_cnt=2 in IDLE, then en0=1 → clk_out0 = 1,1,0,0 repeating; tick0 high on every first '1'; pending0 stays 0.
- ch1 ratio=5 high_cnt=2 → 1,1,0,0,0 repeating. ch2 ratio=5 high_cnt=0 → clk_out2 constant 0 while tick2 still pulses every 5 cycles. ch0 is unaffected throughout.
- ch0 running 4/2; assert load with 6/3 at cnt=1 → the current period finishes as 1,1,0,0 with pending0=1, then 1,1,1,0,0,0 follows. pending0 drops on the wrap edge and tick0 fires there.
- Load on the exact wrap edge: old config is used for one more period and the new config applies at the next boundary. Two loads in one period: only the second is applied.
- Clamp and duty edge cases:
  - load ratio=0 or 1 → behaves as ratio 2: 1,0 repeating with high_cnt=1.
  - ratio=3 high_cnt=7 → clk_out constant 1, tick every 3 cycles.
- en0 deasserted mid high phase → clk_out0=0 on that edge. Re-assert → restart at cnt=0 with clk_out0=1 and tick0=1.
- Synchronous reset mid-run with pending=1 → all outputs 0 and pending 0. A later en=1 without load gives the default 1,0 pattern (ratio 2, high 1).
